boot_mem_ctrl: RTL and testbench

//  Bus-side controller in front of the combinational boot ROM. Accepts reads from the core's

---
 rtl/boot_mem_pkg.sv | 26 ++
 rtl/boot_mem_rsp_reg.sv | 31 +++
 rtl/boot_mem_ctrl.sv | 109 ++++++++++
 tb/tb_boot_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_mem_pkg.sv
// Shared types and helpers for the boot ROM bus controller.
// Address-window check is kept here so both request ports decode identically.
package boot_mem_pkg;

  localparam int unsigned ROM_AW_DEFAULT = 14;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  // True when addr is word aligned and its bits above aw match the window base.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input int unsigned aw);
    logic [31:0] mask;
    mask = ~((32'd1 << aw) - 32'd1);
    return ((addr & mask) == (base & mask)) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/boot_mem_rsp_reg.sv
// Per-port response register: captures ROM data (or an error) on grant and presents it
// for exactly one cycle; read data holds between responses.
module boot_mem_rsp_reg
  import boot_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_err,
  input  logic [31:0] i_rdata,
  output rsp_t        o_rsp
);

  rsp_t r_rsp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp <= '0;
    end else begin
      r_rsp.rvalid <= i_load;
      r_rsp.err    <= i_load & i_err;
      // Errored responses return zero so ROM contents never leak on a rejected access.
      if (i_load) begin
        r_rsp.rdata <= i_err ? 32'h0 : i_rdata;
      end
    end
  end

  assign o_rsp = r_rsp;

endmodule

// File: rtl/boot_mem_ctrl.sv
// Boot ROM bus controller: arbitrates instruction and data read ports onto one ROM port,
// rejects writes and bad addresses, and returns registered responses one cycle after grant.
module boot_mem_ctrl
  import boot_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ROM_AW    = ROM_AW_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_instr_req,
  input  logic [31:0] i_instr_addr,
  output logic        o_instr_gnt,
  output logic        o_instr_rvalid,
  output logic [31:0] o_instr_rdata,
  output logic        o_instr_err,

  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [3:0]  i_data_be,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_gnt,
  output logic        o_data_rvalid,
  output logic [31:0] o_data_rdata,
  output logic        o_data_err,

  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_rdata
);

  port_t r_last_grant;
  logic  w_gnt_instr;
  logic  w_gnt_data;
  logic  w_instr_err;
  logic  w_data_err;
  rsp_t  w_instr_rsp;
  rsp_t  w_data_rsp;
  logic  w_unused;

  // Read-only target: byte enables and write data carry no meaning here.
  assign w_unused = ^{i_data_be, i_data_wdata};

  always_comb begin
    w_gnt_instr = 1'b0;
    w_gnt_data  = 1'b0;
    if (i_instr_req && i_data_req) begin
      // Tie goes to whichever port lost the previous contested or uncontested grant.
      if (r_last_grant == PORT_INSTR) begin
        w_gnt_data = 1'b1;
      end else begin
        w_gnt_instr = 1'b1;
      end
    end else begin
      w_gnt_instr = i_instr_req;
      w_gnt_data  = i_data_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= PORT_INSTR;
    end else if (w_gnt_data) begin
      r_last_grant <= PORT_DATA;
    end else if (w_gnt_instr) begin
      r_last_grant <= PORT_INSTR;
    end
  end

  always_comb begin
    o_rom_addr = {i_instr_addr[31:2], 2'b00};
    if (w_gnt_data) begin
      o_rom_addr = {i_data_addr[31:2], 2'b00};
    end
  end

  assign w_instr_err = !addr_ok(i_instr_addr, BASE_ADDR, ROM_AW);
  assign w_data_err  = !addr_ok(i_data_addr, BASE_ADDR, ROM_AW) || i_data_we;

  boot_mem_rsp_reg u_instr_rsp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_gnt_instr),
    .i_err   (w_instr_err),
    .i_rdata (i_rom_rdata),
    .o_rsp   (w_instr_rsp)
  );

  boot_mem_rsp_reg u_data_rsp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_gnt_data),
    .i_err   (w_data_err),
    .i_rdata (i_rom_rdata),
    .o_rsp   (w_data_rsp)
  );

  assign o_instr_gnt    = w_gnt_instr;
  assign o_instr_rvalid = w_instr_rsp.rvalid;
  assign o_instr_err    = w_instr_rsp.err;
  assign o_instr_rdata  = w_instr_rsp.rdata;

  assign o_data_gnt     = w_gnt_data;
  assign o_data_rvalid  = w_data_rsp.rvalid;
  assign o_data_err     = w_data_rsp.err;
  assign o_data_rdata   = w_data_rsp.rdata;

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Self-checking bench for boot_mem_ctrl: directed vector table, reset corner cases and
// randomized traffic checked against a transaction-level reference model.
module tb_boot_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dbe;
  logic        igot, dgot, ivld, dvld, ierr, derr;
  logic [31:0] ird, drd, rom_addr, rom_rdata;

  always #5 clk = ~clk;

  boot_mem_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_instr_req    (ireq),
    .i_instr_addr   (iaddr),
    .o_instr_gnt    (igot),
    .o_instr_rvalid (ivld),
    .o_instr_rdata  (ird),
    .o_instr_err    (ierr),
    .i_data_req     (dreq),
    .i_data_we      (dwe),
    .i_data_be      (dbe),
    .i_data_addr    (daddr),
    .i_data_wdata   (dwdata),
    .o_data_gnt     (dgot),
    .o_data_rvalid  (dvld),
    .o_data_rdata   (drd),
    .o_data_err     (derr),
    .o_rom_addr     (rom_addr),
    .i_rom_rdata    (rom_rdata)
  );

  // Boot ROM image stand-in: a few known words, a recognisable pattern elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h08c0_006f;
      32'h0000_0090: return 32'h0000_0093;
      32'h0000_0094: return 32'h0000_0113;
      default:       return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign rom_rdata = rom_word(rom_addr);

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic        gi;
    logic        gd;
    logic [31:0] rom_a;
    logic        ivld;
    logic        ierr;
    logic [31:0] ird;
    logic        dvld;
    logic        derr;
    logic [31:0] drd;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a_ireq, input logic [31:0] a_iaddr,
                              input logic a_dreq, input logic a_dwe,
                              input logic [31:0] a_daddr, input logic e_gi, input logic e_gd,
                              input logic [31:0] e_rom, input logic e_ivld, input logic e_ierr,
                              input logic [31:0] e_ird, input logic e_dvld, input logic e_derr,
                              input logic [31:0] e_drd);
    vec_t v;
    v.ireq = a_ireq; v.iaddr = a_iaddr; v.dreq = a_dreq; v.dwe = a_dwe; v.daddr = a_daddr;
    v.gi = e_gi; v.gd = e_gd; v.rom_a = e_rom;
    v.ivld = e_ivld; v.ierr = e_ierr; v.ird = e_ird;
    v.dvld = e_dvld; v.derr = e_derr; v.drd = e_drd;
    return v;
  endfunction

  // Reference model state: who won the most recent grant, and each port's held read data.
  bit          m_data_won_last;
  logic [31:0] m_ird, m_drd;

  function automatic bit legal(input logic [31:0] a, input logic we);
    longint unsigned off;
    off = longint'(a);
    return !we && (off % 4 == 0) && (off < 64'd16384);
  endfunction

  task automatic model_reset();
    m_data_won_last = 1'b0;
    m_ird = 32'h0;
    m_drd = 32'h0;
  endtask

  task automatic model_step(input logic a_ireq, input logic [31:0] a_iaddr, input logic a_dreq,
                            input logic a_dwe, input logic [31:0] a_daddr, output vec_t e);
    bit gi, gd, ie, de;
    if (a_ireq && a_dreq) begin
      gd = !m_data_won_last;
      gi = !gd;
    end else begin
      gi = a_ireq;
      gd = a_dreq;
    end
    if (gi) m_data_won_last = 1'b0;
    if (gd) m_data_won_last = 1'b1;
    ie = gi && !legal(a_iaddr, 1'b0);
    de = gd && !legal(a_daddr, a_dwe);
    if (gi) m_ird = ie ? 32'h0 : rom_word(a_iaddr - (a_iaddr % 4));
    if (gd) m_drd = de ? 32'h0 : rom_word(a_daddr - (a_daddr % 4));
    e = mk(a_ireq, a_iaddr, a_dreq, a_dwe, a_daddr, gi, gd,
           gd ? a_daddr - (a_daddr % 4) : a_iaddr - (a_iaddr % 4),
           gi, ie, m_ird, gd, de, m_drd);
  endtask

  task automatic run_cycle(input vec_t v, input string tag);
    @(negedge clk);
    ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq; dwe = v.dwe; daddr = v.daddr;
    dbe = 4'($urandom); dwdata = $urandom;
    #1;
    chk({tag, ".instr_gnt"}, 32'(igot), 32'(v.gi));
    chk({tag, ".data_gnt"}, 32'(dgot), 32'(v.gd));
    chk({tag, ".rom_addr"}, rom_addr, v.rom_a);
    @(posedge clk);
    #1;
    chk({tag, ".instr_rvalid"}, 32'(ivld), 32'(v.ivld));
    chk({tag, ".instr_err"}, 32'(ierr), 32'(v.ierr));
    chk({tag, ".instr_rdata"}, ird, v.ird);
    chk({tag, ".data_rvalid"}, 32'(dvld), 32'(v.dvld));
    chk({tag, ".data_err"}, 32'(derr), 32'(v.derr));
    chk({tag, ".data_rdata"}, drd, v.drd);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned kind;
    kind = $urandom_range(0, 9);
    if (kind < 7)       return $urandom & 32'h0000_3FFC;
    else if (kind == 7) return ($urandom & 32'h0000_3FFC) | 32'($urandom_range(1, 3));
    else                return ($urandom | 32'h0000_4000) & 32'hFFFF_FFFC;
  endfunction

  vec_t vecs[13];
  vec_t e;

  initial begin
    rst_n = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dbe = 4'h0; dwdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.instr_rvalid", 32'(ivld), 32'h0);
    chk("reset.data_rvalid", 32'(dvld), 32'h0);
    chk("reset.instr_err", 32'(ierr), 32'h0);
    chk("reset.data_err", 32'(derr), 32'h0);
    chk("reset.instr_rdata", ird, 32'h0);
    chk("reset.data_rdata", drd, 32'h0);
    rst_n = 1'b1;

    // ireq iaddr dreq we daddr | gi gd rom_addr | ivld ierr ird | dvld derr drd
    vecs[0]  = mk(1, 32'h0,    0, 0, 32'h0,    1, 0, 32'h0,    1, 0, 32'h08c0006f, 0, 0, 32'h0);
    vecs[1]  = mk(1, 32'h90,   1, 0, 32'h94,   0, 1, 32'h94,   0, 0, 32'h08c0006f, 1, 0, 32'h113);
    vecs[2]  = mk(1, 32'h90,   1, 0, 32'h94,   1, 0, 32'h90,   1, 0, 32'h93, 0, 0, 32'h113);
    vecs[3]  = mk(1, 32'h90,   1, 0, 32'h94,   0, 1, 32'h94,   0, 0, 32'h93, 1, 0, 32'h113);
    vecs[4]  = mk(1, 32'h90,   1, 0, 32'h94,   1, 0, 32'h90,   1, 0, 32'h93, 0, 0, 32'h113);
    vecs[5]  = mk(1, 32'h90,   1, 0, 32'h94,   0, 1, 32'h94,   0, 0, 32'h93, 1, 0, 32'h113);
    vecs[6]  = mk(1, 32'h90,   1, 0, 32'h94,   1, 0, 32'h90,   1, 0, 32'h93, 0, 0, 32'h113);
    vecs[7]  = mk(0, 32'h0,    1, 1, 32'h10,   0, 1, 32'h10,   0, 0, 32'h93, 1, 1, 32'h0);
    vecs[8]  = mk(0, 32'h0,    1, 0, 32'h4000, 0, 1, 32'h4000, 0, 0, 32'h93, 1, 1, 32'h0);
    vecs[9]  = mk(0, 32'h0,    1, 0, 32'h2,    0, 1, 32'h0,    0, 0, 32'h93, 1, 1, 32'h0);
    vecs[10] = mk(1, 32'h8000, 0, 0, 32'h0,    1, 0, 32'h8000, 1, 1, 32'h0,  0, 0, 32'h0);
    vecs[11] = mk(0, 32'h7,    0, 0, 32'h0,    0, 0, 32'h4,    0, 0, 32'h0,  0, 0, 32'h0);
    vecs[12] = mk(0, 32'h0,    1, 0, 32'h20,   0, 1, 32'h20,   0, 0, 32'h0,  1, 0, 32'hC0DE0020);

    for (int i = 0; i < 13; i++) begin
      model_step(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, e);
      run_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 16; k++) begin
      model_step(1'b1, 32'(4 * k), 1'b0, 1'b0, 32'h0, e);
      run_cycle(e, $sformatf("stream%0d", k));
    end

    // Reset lands before the edge that would have produced the response.
    @(negedge clk);
    ireq = 1'b1; iaddr = 32'h8; dreq = 1'b0;
    #1 chk("rst_pre.instr_gnt", 32'(igot), 32'h1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pre.instr_rvalid", 32'(ivld), 32'h0);
    chk("rst_pre.instr_rdata", ird, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ireq = 1'b0;
    model_reset();
    model_step(1'b1, 32'h90, 1'b1, 1'b0, 32'h94, e);
    chk("rst_pre.tie_model_data", 32'(e.gd), 32'h1);
    run_cycle(e, "rst_tie0");
    model_step(1'b1, 32'h90, 1'b0, 1'b0, 32'h0, e);
    run_cycle(e, "rst_tie1");

    // Reset asserted while a response is on the bus drops it immediately.
    @(negedge clk);
    ireq = 1'b1; iaddr = 32'h0; dreq = 1'b0;
    @(posedge clk);
    #1 chk("rst_mid.instr_rvalid_before", 32'(ivld), 32'h1);
    rst_n = 1'b0;
    #1 chk("rst_mid.instr_rvalid_after", 32'(ivld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ireq = 1'b0;
    model_reset();

    begin
      bit          pi = 1'b0, pd = 1'b0;
      logic [31:0] ai = 32'h0, ad = 32'h0;
      logic        we = 1'b0;
      for (int n = 0; n < 400; n++) begin
        // Requester holds req/addr stable until granted.
        if (!pi) begin
          pi = ($urandom_range(0, 3) != 0);
          ai = rand_addr();
        end
        if (!pd) begin
          pd = ($urandom_range(0, 2) != 0);
          ad = rand_addr();
          we = ($urandom_range(0, 7) == 0);
        end
        model_step(pi, ai, pd, we, ad, e);
        run_cycle(e, $sformatf("rand%0d", n));
        if (e.gi) pi = 1'b0;
        if (e.gd) pd = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
